// File: rtl/fsb_rr_arbiter_pkg.sv
// Shared FSB definitions: packet width/type, output buffer states and the
// source-tag width helper.
package fsb_rr_arbiter_pkg;

    localparam int unsigned fsb_width_c = 80;

    typedef logic [fsb_width_c-1:0] fsb_pkt_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Width of a source index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fsb_rr_arbiter_if.sv
// FSB source/sink bundle for the round-robin arbiter: the request side
// (per-source valid/data/yumi) and the merged output side (valid/data/id/ready).
interface fsb_rr_arbiter_if
    import fsb_rr_arbiter_pkg::*;
#(
    parameter int unsigned num_req_p   = 4,
    parameter int unsigned fsb_width_p = fsb_width_c,
    parameter int unsigned id_width_lp = id_width(num_req_p)
);

    logic [num_req_p-1:0]             req_v_i;
    logic [num_req_p*fsb_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]             req_yumi_o;
    logic                             fsb_v_o;
    logic [fsb_width_p-1:0]           fsb_data_o;
    logic [id_width_lp-1:0]           fsb_id_o;
    logic                             fsb_ready_i;

    // Arbiter side.
    modport slave (
        input  req_v_i, req_data_i, fsb_ready_i,
        output req_yumi_o, fsb_v_o, fsb_data_o, fsb_id_o
    );

    // Sources/sink side.
    modport master (
        output req_v_i, req_data_i, fsb_ready_i,
        input  req_yumi_o, fsb_v_o, fsb_data_o, fsb_id_o
    );

endinterface

// File: rtl/fsb_rr_arb_core.sv
// Combinational round-robin pick: first eligible source after last_grant,
// wrapping modulo num_req_p. Only produces a grant when can_load is set.
module fsb_rr_arb_core
    import fsb_rr_arbiter_pkg::*;
#(
    parameter  int unsigned num_req_p   = 4,
    localparam int unsigned id_width_lp = id_width(num_req_p)
) (
    input  logic [num_req_p-1:0]   elig,
    input  logic [id_width_lp-1:0] last_grant,
    input  logic                   can_load,
    output logic [num_req_p-1:0]   grant_oh,
    output logic [id_width_lp-1:0] grant_id,
    output logic                   grant_v
);

    int unsigned          idx;
    logic [num_req_p-1:0] sel;

    // Rotating priority search starting one past the previous winner.
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        grant_v  = 1'b0;
        idx      = 0;
        sel      = '0;
        if (can_load) begin
            for (int unsigned off = 1; off <= num_req_p; off++) begin
                idx = (32'(last_grant) + off) % num_req_p;
                sel = num_req_p'(1) << idx;
                if (!grant_v && |(elig & sel)) begin
                    grant_v  = 1'b1;
                    grant_oh = sel;
                    grant_id = id_width_lp'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/fsb_rr_arbiter.sv
// Round-robin merge of num_req_p FSB sources into one sink through a
// single-entry output register, with source tagging and saturating
// per-source grant counters.
module fsb_rr_arbiter
    import fsb_rr_arbiter_pkg::*;
#(
    parameter  int unsigned num_req_p   = 4,
    parameter  int unsigned fsb_width_p = fsb_width_c,
    parameter  int unsigned cnt_width_p = 16,
    localparam int unsigned id_width_lp = id_width(num_req_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             en_mask_i,
    input  logic                             cnt_clear_i,
    output logic [num_req_p*cnt_width_p-1:0] pkt_cnt_o,
    fsb_rr_arbiter_if.slave                  bus
);

    buf_state_e             state_r, state_n;
    logic [id_width_lp-1:0] last_grant_r;
    logic [id_width_lp-1:0] grant_id;
    logic [num_req_p-1:0]   grant_oh;
    logic [num_req_p-1:0]   elig;
    logic                   grant_v;
    logic                   can_load;
    logic [fsb_width_p-1:0] data_r;
    logic [id_width_lp-1:0] id_r;
    logic [fsb_width_p-1:0] grant_data;

    assign elig = bus.req_v_i & en_mask_i;

    // Gated by reset so no packet is consumed while the buffer is held empty.
    assign can_load = reset_n_i & ((state_r == BUF_EMPTY) | bus.fsb_ready_i);

    fsb_rr_arb_core #(
        .num_req_p (num_req_p)
    ) u_core (
        .elig       (elig),
        .last_grant (last_grant_r),
        .can_load   (can_load),
        .grant_oh   (grant_oh),
        .grant_id   (grant_id),
        .grant_v    (grant_v)
    );

    assign grant_data = fsb_width_p'(bus.req_data_i >> (fsb_width_p * 32'(grant_id)));

    assign bus.req_yumi_o = grant_oh;
    assign bus.fsb_v_o    = (state_r == BUF_FULL);
    assign bus.fsb_data_o = data_r;
    assign bus.fsb_id_o   = id_r;

    // Output buffer state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    // Buffer fills on any grant, drains when the sink takes it and nothing refills.
    always_comb begin
        state_n = state_r;
        if (grant_v) begin
            state_n = BUF_FULL;
        end else if ((state_r == BUF_FULL) && bus.fsb_ready_i) begin
            state_n = BUF_EMPTY;
        end
    end

    // Output payload, tag and round-robin pointer capture on grant.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r       <= '0;
            id_r         <= '0;
            last_grant_r <= id_width_lp'(num_req_p - 1);
        end else if (grant_v) begin
            data_r       <= grant_data;
            id_r         <= grant_id;
            last_grant_r <= grant_id;
        end
    end

    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        logic [cnt_width_p-1:0] cnt_r;

        // Saturating grant counter; clear takes precedence over increment.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_r <= '0;
            end else if (cnt_clear_i) begin
                cnt_r <= '0;
            end else if (grant_oh[i] && (cnt_r != '1)) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end

        assign pkt_cnt_o[cnt_width_p*i +: cnt_width_p] = cnt_r;
    end

endmodule

// File: doc/fsb_rr_arbiter.md
Name: fsb_rr_arbiter

Overview:
Round-robin arbiter that merges num_req_p independent FSB source streams (80-bit single-beat packets) into one FSB sink, e.g. several accelerator FSB masters sharing one host-facing AXI-Lite/FSB adapter slot.
- Buffers one packet in an output register, which allows full throughput (one packet per cycle).
- Tags each output packet with its source index.
- Keeps saturating per-source packet counters for host-side debug.

Parameters:
num_req_p, 4, number of requesting FSB sources (1..16)
fsb_width_p, 80, FSB packet width in bits
cnt_width_p, 16, width of each per-source packet counter
id_width_lp, max(1,$clog2(num_req_p)), local; width of the source tag

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
en_mask_i  in  num_req_p  per-source enable; 0 = source never granted
req_v_i  in  num_req_p  source packet valid
req_data_i  in  num_req_p*fsb_width_p  source packets, source i at [fsb_width_p*i +: fsb_width_p]
req_yumi_o  out  num_req_p  one-hot or zero; packet i consumed this cycle
fsb_v_o  out  1  output packet valid
fsb_data_o  out  fsb_width_p  output packet
fsb_id_o  out  id_width_lp  source index of fsb_data_o
fsb_ready_i  in  1  sink ready; transfer occurs when fsb_v_o & fsb_ready_i
cnt_clear_i  in  1  synchronous clear of all counters
pkt_cnt_o  out  num_req_p*cnt_width_p  granted-packet count per source, source i at [cnt_width_p*i +: cnt_width_p]

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - fsb_v_o=0, fsb_data_o=0, fsb_id_o=0, all counters 0.
  - last_grant = num_req_p-1, so source 0 has top priority first.
  - req_yumi_o is 0 during reset.
- Output buffer states:
  - EMPTY (fsb_v_o=0) and FULL (fsb_v_o=1).
  - can_load = EMPTY | (FULL & fsb_ready_i).
- Eligible set: elig = req_v_i & en_mask_i.
- Grant (combinational):
  - Only when can_load & |elig.
  - Pick the first eligible index searching last_grant+1, last_grant+2, ... modulo num_req_p.
  - req_yumi_o[g] = 1 in the same cycle; all other yumi bits = 0.
  - yumi may depend combinationally on req_v_i, en_mask_i and fsb_ready_i. No path from req_data_i.
- On grant (clock edge):
  - fsb_data_o <= req_data_i slice g; fsb_id_o <= g; fsb_v_o <= 1; last_grant <= g.
- No grant while can_load:
  - FULL with fsb_ready_i=1 → EMPTY.
  - EMPTY stays EMPTY.
  - last_grant unchanged.
- FULL & !fsb_ready_i:
  - fsb_data_o and fsb_id_o hold stable; no grant; all yumi = 0.
- Latency: packet granted in cycle t appears on fsb_v_o in cycle t+1. Sustained rate is 1 packet/cycle with fsb_ready_i held high.
- Fairness: with k continuously eligible sources, each is granted exactly once per k grants.
- en_mask_i change:
  - Affects grants from the same cycle.
  - A packet already buffered is still delivered.
  - Clearing a source's bit while it is valid simply leaves its packet unconsumed.
- Counters:
  - pkt_cnt[g] increments on each grant of g and saturates at 2^cnt_width_p-1.
  - cnt_clear_i=1 zeroes all counters at the next edge. Clear wins over a same-cycle increment.
- num_req_p=1: fsb_id_o is constant 0 and the arbiter degenerates to a one-entry pipe register.
- Reset asserted mid-transfer: the buffered packet is dropped (fsb_v_o → 0 immediately, asynchronously).

Decomposition:
- Shared package: fsb_width constant (80) and the fsb packet typedef, shared with the AXI-Lite/FSB adapter; id-width helper function.
- One sub-module, fsb_rr_arb_core:
  - Purely combinational.
  - Inputs: elig vector, last_grant, can_load.
  - Outputs: one-hot grant, encoded grant index, grant_v.
- Output buffer, pointer register and counters live in the top.

Test Plan:
- Reset release, all four sources valid and enabled, fsb_ready_i=1 → yumi sequence 0001,0010,0100,1000,0001; fsb_id_o 0,1,2,3,0 one cycle later; pkt_cnt_o each 1 after the 4th grant.
- Only sources 1 and 3 valid; fsb_ready_i low for 5 cycles after first grant → fsb_data_o/fsb_id_o=1 held stable, yumi all 0 during stall; resume → id 3 next, then 1.
- en_mask_i=4'b1011 with all valid → source 2 never granted; pattern 0,1,3,0,1,3; pkt_cnt[2] stays 0.
- cnt_width_p=4, source 0 alone granted 20 times → pkt_cnt[0] saturates at 15. cnt_clear_i asserted in a grant cycle → counter reads 0 next cycle.
- Assert reset_n_i low mid-stream while FULL → fsb_v_o drops without a clock edge. After release, first grant goes to source 0 regardless of prior pointer.
- Random valid/ready/mask traffic, 10k cycles, scoreboard → every yumi'd packet emitted exactly once, in grant order, with correct id; no yumi while FULL & !fsb_ready_i.
